// File: rtl/bus_deserializer.sv
// Collects BUS_SIZE-bit words into an IDX_COUNT-slot registered frame and hands the frame downstream.
// Optional macro BUS_DESERIALIZER_PARTIAL_EN: when defined, a flushed partial frame is emitted instead of discarded.
module bus_deserializer #(
  parameter int BUS_SIZE  = 16,
  parameter int IDX_COUNT = 16,
  parameter int IDX_SIZE  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BUS_SIZE-1:0]           in_data,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_COUNT*BUS_SIZE-1:0] out_bus,
  output logic [IDX_SIZE:0]             out_words
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t              state, state_next;
  logic [IDX_SIZE-1:0] idx, idx_next;
  logic [IDX_SIZE:0]   words_next;
  logic [IDX_SIZE:0]   count_after;
  logic                hs_in;
  logic                last_slot;
  logic                write_en;
  logic                clear_bus;

  // Ready depends only on registered state, and is forced low while reset is held.
  assign in_ready    = rst_n && (state == FILL);
  assign out_valid   = (state == HOLD);
  assign hs_in       = in_valid && in_ready;
  assign last_slot   = (idx == IDX_SIZE'(IDX_COUNT - 1));
  assign count_after = {1'b0, idx} + {{IDX_SIZE{1'b0}}, hs_in};

  always_comb begin
    state_next = state;
    idx_next   = idx;
    words_next = out_words;
    write_en   = 1'b0;
    clear_bus  = 1'b0;
    case (state)
      FILL: begin
        write_en = hs_in;
        if (hs_in && last_slot) begin
          state_next = HOLD;
          words_next = (IDX_SIZE+1)'(IDX_COUNT);
          idx_next   = '0;
        end else if (flush && (count_after != '0)) begin
`ifdef BUS_DESERIALIZER_PARTIAL_EN
          state_next = HOLD;
          words_next = count_after;
          idx_next   = '0;
`else
          // Discarding also drops a word accepted in the flush cycle.
          clear_bus  = 1'b1;
          idx_next   = '0;
`endif
        end else if (hs_in) begin
          idx_next = idx + IDX_SIZE'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = FILL;
          clear_bus  = 1'b1;
          words_next = '0;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= '0;
      out_words <= '0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      out_words <= words_next;
    end
  end

  // Clearing on release keeps every unwritten slot at zero for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bus <= '0;
    end else if (clear_bus) begin
      out_bus <= '0;
    end else if (write_en) begin
      out_bus[idx*BUS_SIZE +: BUS_SIZE] <= in_data;
    end
  end

endmodule

// File: tb/tb_bus_deserializer.sv
// Self-checking bench for bus_deserializer with 4 slots of 16 bits.
// Expectations follow the build: BUS_DESERIALIZER_PARTIAL_EN selects the partial-frame results.
module tb_bus_deserializer;

  localparam int BS = 16;
  localparam int IC = 4;
  localparam int IS = 2;
  localparam int OW = IC * BS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [BS-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_bus;
  logic [IS:0]   out_words;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          v;
    logic [BS-1:0] d;
    logic          f;
    logic          ordy;
    logic          eir;
    logic          eov;
    logic [OW-1:0] ebus;
    logic [IS:0]   ew;
  } vec_t;

  vec_t vecs[$];

  bus_deserializer #(.BUS_SIZE(BS), .IDX_COUNT(IC), .IDX_SIZE(IS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_bus(out_bus), .out_words(out_words)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void addVec(input logic v, input logic [BS-1:0] d, input logic f, input logic ordy,
                                 input logic eir, input logic eov, input logic [OW-1:0] ebus, input logic [IS:0] ew);
    vec_t r;
    r.v = v; r.d = d; r.f = f; r.ordy = ordy;
    r.eir = eir; r.eov = eov; r.ebus = ebus; r.ew = ew;
    vecs.push_back(r);
  endfunction

  // Four words base, base+step, ... then holdCycles of backpressure, release, one idle cycle.
  function automatic void addFrame(input logic [BS-1:0] base, input logic [BS-1:0] step,
                                   input int holdCycles, input logic rdy);
    logic [OW-1:0] acc = '0;
    logic [BS-1:0] w;
    for (int i = 0; i < IC; i++) begin
      w = base + BS'(i) * step;
      addVec(1'b1, w, 1'b0, rdy, 1'b1, 1'b0, acc, 3'd0);
      acc[i*BS +: BS] = w;
    end
    for (int h = 0; h < holdCycles; h++)
      addVec(1'b1, 16'hDEAD, h[0], 1'b0, 1'b0, 1'b1, acc, 3'd4);
    addVec(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b1, acc, 3'd4);
    addVec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, '0, 3'd0);
  endfunction

  function automatic void buildVectors();
    logic [OW-1:0] acc = '0;
    // flush at idx 0 is a no-op
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, '0, 3'd0);
    addFrame(16'h1111, 16'h1111, 0, 1'b1);
    addFrame(16'hA001, 16'h0001, 10, 1'b0);
    addFrame(16'hB001, 16'h0001, 1, 1'b0);
    // flush together with the final word completes normally
    for (int i = 0; i < IC - 1; i++) begin
      addVec(1'b1, 16'hC001 + BS'(i), 1'b0, 1'b0, 1'b1, 1'b0, acc, 3'd0);
      acc[i*BS +: BS] = 16'hC001 + BS'(i);
    end
    addVec(1'b1, 16'hC004, 1'b1, 1'b0, 1'b1, 1'b0, acc, 3'd0);
    acc[63:48] = 16'hC004;
    addVec(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, acc, 3'd4);
    addVec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, '0, 3'd0);
    // partial flush without a handshake
    addVec(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, '0, 3'd0);
    addVec(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_AAAA, 3'd0);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0000_0000_BBBB_AAAA, 3'd0);
`ifdef BUS_DESERIALIZER_PARTIAL_EN
    addVec(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0000_0000_BBBB_AAAA, 3'd2);
    addVec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, '0, 3'd0);
`else
    addVec(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0);
`endif
    addFrame(16'hD001, 16'h0001, 0, 1'b0);
    // partial flush in the same cycle as a handshake
    addVec(1'b1, 16'hE001, 1'b0, 1'b0, 1'b1, 1'b0, '0, 3'd0);
    addVec(1'b1, 16'hE002, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_E001, 3'd0);
`ifdef BUS_DESERIALIZER_PARTIAL_EN
    addVec(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0000_0000_E002_E001, 3'd2);
`endif
    addVec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, '0, 3'd0);
    addFrame(16'hF001, 16'h0001, 2, 1'b0);
  endfunction

  // Offer one word after a gap and wait (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [BS-1:0] w, input int gap);
    int n = 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = BS'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake timeout: in_ready stayed %b, expected 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic releaseFrame(input int holdCycles);
    for (int h = 0; h < holdCycles; h++) @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("release out_valid", OW'(out_valid), '0);
  endtask

  initial begin
    logic [OW-1:0] exp;
    logic [BS-1:0] w;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", OW'(in_ready), '0);
    checkOutput("reset out_valid", OW'(out_valid), '0);
    checkOutput("reset out_bus", out_bus, '0);
    checkOutput("reset out_words", OW'(out_words), '0);
    rst_n = 1'b1;

    buildVectors();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("row%0d in_ready", i), OW'(in_ready), OW'(vecs[i].eir));
      checkOutput($sformatf("row%0d out_valid", i), OW'(out_valid), OW'(vecs[i].eov));
      checkOutput($sformatf("row%0d out_bus", i), out_bus, vecs[i].ebus);
      checkOutput($sformatf("row%0d out_words", i), OW'(out_words), OW'(vecs[i].ew));
      in_valid  = vecs[i].v;
      in_data   = vecs[i].d;
      flush     = vecs[i].f;
      out_ready = vecs[i].ordy;
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // three frames with random valid gaps
    for (int fr = 0; fr < 3; fr++) begin
      exp = '0;
      for (int i = 0; i < IC; i++) begin
        w = BS'($urandom);
        exp[i*BS +: BS] = w;
        applyStimulus(w, int'($urandom_range(0, 3)));
      end
      @(negedge clk);
      checkOutput($sformatf("gap frame%0d out_valid", fr), OW'(out_valid), 1);
      checkOutput($sformatf("gap frame%0d out_bus", fr), out_bus, exp);
      checkOutput($sformatf("gap frame%0d out_words", fr), OW'(out_words), 4);
      releaseFrame(int'($urandom_range(0, 2)));
    end

    // reset while a full frame is held
    for (int i = 0; i < IC; i++) applyStimulus(16'h9001 + BS'(i), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("held reset out_valid", OW'(out_valid), '0);
    checkOutput("held reset out_bus", out_bus, '0);
    checkOutput("held reset out_words", OW'(out_words), '0);
    checkOutput("held reset in_ready", OW'(in_ready), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset mid-frame, next word must land in slot 0
    applyStimulus(16'h8001, 0);
    applyStimulus(16'h8002, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("mid reset out_bus", out_bus, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < IC; i++) applyStimulus(16'h7001 + BS'(i), 0);
    @(negedge clk);
    checkOutput("post reset out_bus", out_bus, 64'h7004_7003_7002_7001);
    checkOutput("post reset out_words", OW'(out_words), 4);
    releaseFrame(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_deserializer.md
# bus_deserializer

- Sequential counterpart of the combinational demultiplexer.
- Accepts a stream of `BUS_SIZE`-bit words over a valid/ready handshake and writes each word into the next slot of a wide registered output bus.
- Presents the assembled `IDX_COUNT`-word frame downstream with its own valid/ready handshake.
- Sits at the receive end of a time-multiplexed narrow link, restoring a wide bus that was serialised word by word by an index-stepping multiplexer.

## Interface
- `BUS_SIZE`, 16, width of one word.
- `IDX_COUNT`, 16, words per frame; any value ≥ 2, need not be a power of two.
- `IDX_SIZE`, 4, slot-counter width; must satisfy 2^`IDX_SIZE` ≥ `IDX_COUNT`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can take a word.
- `in_data`  in  `BUS_SIZE`  word; slot i occupies bits [i*`BUS_SIZE` +: `BUS_SIZE`].
- `flush`  in  1  close the current partial frame (synchronous, one cycle).
- `out_valid`  out  1  frame available.
- `out_ready`  in  1  downstream takes the frame.
- `out_bus`  out  `IDX_COUNT`*`BUS_SIZE`  assembled frame, registered.
- `out_words`  out  `IDX_SIZE`+1  number of valid slots in the presented frame (1..`IDX_COUNT`).

## Operation
- **FSM states:** FILL and HOLD. Reset enters FILL with slot counter `idx` = 0.
- **Reset values:** `out_bus` = 0, `out_words` = 0, `out_valid` = 0. `in_ready` = 0 while `rst_n` is low.
- **FILL:**
  - `in_ready` = 1.
  - Input handshake is `in_valid` & `in_ready`. On a handshake, slot `idx` is written with `in_data` and `idx` increments.
  - Handshake with `idx` = `IDX_COUNT`-1: go to HOLD, `out_words` = `IDX_COUNT`, `idx` = 0. `idx` never reaches `IDX_COUNT`.
- **HOLD:**
  - `in_ready` = 0, `out_valid` = 1.
  - `out_bus` and `out_words` are stable until an output handshake (`out_valid` & `out_ready`).
  - On the output handshake: go to FILL, clear all slots to 0, set `out_words` = 0.
- **Flush in FILL:**
  - `flush` with a handshake in the same cycle: the word is stored first, then the frame is closed with `idx`+1 words.
  - `flush` with no handshake: closes `idx` words; if `idx` = 0 it has no effect.
  - The full-frame case (`idx` = `IDX_COUNT`-1 plus a handshake) behaves like a normal completion.
  - What happens to a closed partial frame depends on configuration (see Configuration).
- **Flush in HOLD:** ignored.
- **Unwritten slots:** always 0, because slots are cleared on every frame release.
- `in_data` is not sampled without a handshake. `out_ready` is ignored in FILL.

## Timing
- **Latency:** last word accepted at edge N, so `out_valid` = 1 and `out_bus` valid after edge N; visible in cycle N+1.
- **`in_ready` timing:**
  - `in_ready` is a function of registered state only; no combinational path from `out_ready`.
  - `in_ready` returns to 1 in the cycle after the output handshake.
- **Throughput:** at best one frame per `IDX_COUNT`+1 cycles (at least one HOLD cycle).
- **Backpressure:** `out_ready` held low keeps HOLD indefinitely with no data loss; upstream stalls on `in_ready` = 0.
- **Reset mid-frame:** partial frame and any held frame are discarded; all outputs return to reset values immediately (asynchronously).

## Configuration
- Macro: `BUS_DESERIALIZER_PARTIAL_EN`.
- **Defined:** a flush that closes a partial frame (`idx` ≥ 1 after the flush-cycle word) enters HOLD with `out_words` = word count, unwritten slots 0.
- **Undefined:**
  - A flush that closes a partial frame discards it: slots are cleared, `idx` = 0, and the FSM stays in FILL.
  - `out_words` is then always `IDX_COUNT` when `out_valid` = 1.
  - A flush coinciding with the final word of a full frame still emits it.

## Test plan
Parameters for all tests: `BUS_SIZE`=16, `IDX_COUNT`=4, `IDX_SIZE`=2.
- **Reset:** reset asserted mid-frame -> `out_valid`=0, `out_bus`=0, `out_words`=0, next accepted word lands in slot 0.
- **Full frame:** words 0x1111,0x2222,0x3333,0x4444 back-to-back with `out_ready`=1 -> `out_bus`=0x4444_3333_2222_1111 and `out_valid` one cycle after the last accept; `out_words`=4; `in_ready` low for exactly one cycle.
- **Backpressure:** `out_ready` held low 10 cycles after a full frame -> `out_bus` stable, `in_ready`=0 throughout, and the next frame assembles correctly after release.
- **Random valid gaps:** random `in_valid` gaps -> slot order is preserved; 3 consecutive frames come out bit-exact.
- **Partial flush, macro defined:** 0xAAAA, 0xBBBB, then `flush` with no handshake -> `out_bus`=0x0000_0000_BBBB_AAAA, `out_words`=2.
- **Partial flush, macro undefined:** same stimulus -> no `out_valid`; next four words form a clean frame. In both builds, `flush` in HOLD and `flush` at `idx`=0 have no effect.
